// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Round-robin arbiter sharing one 32-bit, 8-digit seven-segment display word
// between four requesters. The winner's word is registered onto seg_out and
// held for HOLD_CYCLES clocks before another requester may take the display.
module seg_display_arbiter #(
   parameter int          HOLD_CYCLES = 100_000_000,
   parameter int          CNT_W       = 27,
   parameter logic [31:0] INIT_SEG    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic [31:0] data3,
   output logic [3:0]  ack,
   output logic [31:0] seg_out,
   output logic [1:0]  owner,
   output logic        busy
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Counter load value: the grant edge itself plus HOLD_CYCLES-1 decrements
   // gives exactly HOLD_CYCLES cycles of busy.
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [1:0]        last_r, last_s;
   logic [31:0]       seg_r, seg_s;
   logic [3:0]        ack_r, ack_s;
   logic [1:0]        owner_r, owner_s;
   logic              busy_r, busy_s;
   logic [2:0]        win_s;
   logic [31:0]       win_data_s;

   // Round-robin pick: first set request scanning last+1, last+2, last+3, last.
   // Returns {found, index}. Scanning from the far end lets the nearest
   // candidate overwrite the result, giving it priority.
   function automatic logic [2:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (r[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign win_s = pick_winner(req, last_r);

   // Select the candidate winner's data word.
   always_comb begin
      win_data_s = 32'h0000_0000;
      case (win_s[1:0])
         2'd0:    win_data_s = data0;
         2'd1:    win_data_s = data1;
         2'd2:    win_data_s = data2;
         2'd3:    win_data_s = data3;
         default: win_data_s = 32'h0000_0000;
      endcase
   end

   // Next-state and next-output logic for the IDLE/HOLD arbitration FSM.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      last_s  = last_r;
      seg_s   = seg_r;
      ack_s   = 4'b0000;
      owner_s = owner_r;
      busy_s  = busy_r;
      case (state_r)
         IDLE: begin
            if (win_s[2]) begin
               seg_s   = win_data_s;
               ack_s   = 4'b0001 << win_s[1:0];
               owner_s = win_s[1:0];
               last_s  = win_s[1:0];
               cnt_s   = HOLD_LOAD;
               busy_s  = 1'b1;
               state_s = HOLD;
            end else begin
               state_s = IDLE;
            end
         end
         HOLD: begin
            if (cnt_r != {CNT_W{1'b0}}) begin
               cnt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
               state_s = HOLD;
            end else begin
               state_s = IDLE;
               busy_s  = 1'b0;
            end
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset discards any grant in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         last_r  <= 2'd3;
         seg_r   <= INIT_SEG;
         ack_r   <= 4'b0000;
         owner_r <= 2'd0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         last_r  <= last_s;
         seg_r   <= seg_s;
         ack_r   <= ack_s;
         owner_r <= owner_s;
         busy_r  <= busy_s;
      end
   end

   assign ack     = ack_r;
   assign seg_out = seg_r;
   assign owner   = owner_r;
   assign busy    = busy_r;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter with HOLD_CYCLES=4.
// A behavioural model tracks remaining busy cycles and the last winner as
// plain integers and predicts the outputs after each rising edge.
module tb_seg_display_arbiter;

   localparam int          H    = 4;
   localparam logic [31:0] INIT = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] data [4];
   logic [3:0]  ack;
   logic [31:0] seg_out;
   logic [1:0]  owner;
   logic        busy;

   int vectors    = 0;
   int miscompares = 0;

   // model state
   logic [31:0] m_seg;
   logic [3:0]  m_ack;
   logic [1:0]  m_owner;
   logic        m_busy;
   int          m_left;
   int          m_last;

   seg_display_arbiter #(.HOLD_CYCLES(H), .CNT_W(8), .INIT_SEG(INIT)) dut (
      .clk(clk), .reset(reset), .req(req),
      .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
      .ack(ack), .seg_out(seg_out), .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   // predict the result of the coming edge from current inputs
   task automatic model_step();
      int w;
      w = -1;
      if (reset) begin
         m_seg = INIT; m_ack = 4'b0000; m_owner = 2'd0; m_busy = 1'b0;
         m_left = 0; m_last = 3;
      end else if (m_left > 0) begin
         m_ack = 4'b0000;
         m_left = m_left - 1;
         m_busy = (m_left > 0);
      end else begin
         m_ack = 4'b0000;
         for (int k = 1; k <= 4; k++) begin
            if (w < 0 && req[(m_last + k) % 4]) w = (m_last + k) % 4;
         end
         if (w >= 0) begin
            m_seg = data[w]; m_ack = 4'b0001 << w; m_owner = w[1:0];
            m_last = w; m_left = H; m_busy = 1'b1;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   function automatic int ack_idx(input logic [3:0] a);
      int r;
      r = -1;
      for (int i = 0; i < 4; i++) if (a[i]) r = i;
      return r;
   endfunction

   task automatic test_reset();
      reset = 1'b1; req = 4'b1111;
      for (int i = 0; i < 4; i++) data[i] = $urandom;
      for (int c = 0; c < 2; c++) begin
         tick();
         vectors++;
         if ({ack, seg_out, owner, busy} !== {4'b0000, INIT, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset c%0d: got ack=%b seg=%h own=%0d busy=%b, want ack=0000 seg=%h own=0 busy=0",
                     c, ack, seg_out, owner, busy, INIT);
         end
      end
      reset = 1'b0; req = 4'b0000;
      tick();
      vectors++;
      if ({ack, seg_out, busy} !== {4'b0000, INIT, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_idle: got ack=%b seg=%h busy=%b, want 0000 %h 0", ack, seg_out, busy, INIT);
      end
   endtask

   task automatic test_single();
      int busy_cnt;
      data[2] = 32'h1234_5678; req = 4'b0100;
      tick();
      vectors++;
      if ({ack, seg_out, owner, busy} !== {4'b0100, 32'h1234_5678, 2'd2, 1'b1}) begin
         miscompares++;
         $display("FAIL single_grant: got ack=%b seg=%h own=%0d busy=%b, want 0100 12345678 2 1",
                  ack, seg_out, owner, busy);
      end
      req = 4'b0000;
      busy_cnt = 1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (busy) busy_cnt++;
         vectors++;
         if ({ack, seg_out, owner, busy} !== {m_ack, m_seg, m_owner, m_busy}) begin
            miscompares++;
            $display("FAIL single c%0d: got ack=%b seg=%h own=%0d busy=%b, want ack=%b seg=%h own=%0d busy=%b",
                     c, ack, seg_out, owner, busy, m_ack, m_seg, m_owner, m_busy);
         end
      end
      vectors++;
      if (busy_cnt !== H) begin
         miscompares++;
         $display("FAIL single_busy_len: got %0d cycles, want %0d", busy_cnt, H);
      end
   endtask

   task automatic test_full_load();
      int own_q[$];
      int cyc_q[$];
      reset = 1'b1; tick(); reset = 1'b0;
      req = 4'b1111;
      for (int c = 0; c < 30; c++) begin
         tick();
         vectors++;
         if ({ack, seg_out, owner, busy} !== {m_ack, m_seg, m_owner, m_busy}) begin
            miscompares++;
            $display("FAIL full c%0d: got ack=%b seg=%h own=%0d busy=%b, want ack=%b seg=%h own=%0d busy=%b",
                     c, ack, seg_out, owner, busy, m_ack, m_seg, m_owner, m_busy);
         end
         if (ack != 4'b0000) begin
            own_q.push_back(ack_idx(ack));
            cyc_q.push_back(c);
         end
         req = 4'b1111 & ~ack;
         for (int i = 0; i < 4; i++) if (!req[i]) data[i] = $urandom;
      end
      vectors++;
      if (own_q.size() < 5) begin
         miscompares++;
         $display("FAIL full_count: got %0d grants, want at least 5", own_q.size());
      end else begin
         for (int g = 0; g < 5; g++) begin
            vectors++;
            if (own_q[g] !== g % 4) begin
               miscompares++;
               $display("FAIL full_order g%0d: got %0d, want %0d", g, own_q[g], g % 4);
            end
            if (g > 0) begin
               vectors++;
               if (cyc_q[g] - cyc_q[g-1] !== H + 1) begin
                  miscompares++;
                  $display("FAIL full_spacing g%0d: got %0d, want %0d", g, cyc_q[g] - cyc_q[g-1], H + 1);
               end
            end
         end
      end
   endtask

   task automatic test_priority();
      int own_q[$];
      reset = 1'b1; tick(); reset = 1'b0;
      req = 4'b1000;
      tick();
      vectors++;
      if ({ack, owner} !== {4'b1000, 2'd3}) begin
         miscompares++;
         $display("FAIL prio_first: got ack=%b own=%0d, want 1000 3", ack, owner);
      end
      for (int c = 0; c < 12; c++) begin
         req = 4'b1001 & ~ack;
         tick();
         vectors++;
         if ({ack, seg_out, owner, busy} !== {m_ack, m_seg, m_owner, m_busy}) begin
            miscompares++;
            $display("FAIL prio c%0d: got ack=%b own=%0d busy=%b, want ack=%b own=%0d busy=%b",
                     c, ack, owner, busy, m_ack, m_owner, m_busy);
         end
         if (ack != 4'b0000) own_q.push_back(ack_idx(ack));
      end
      vectors++;
      if (own_q.size() < 2 || own_q[0] !== 0 || own_q[1] !== 3) begin
         miscompares++;
         $display("FAIL prio_order: got %0d grants first=%0d second=%0d, want 0 then 3",
                  own_q.size(), (own_q.size() > 0) ? own_q[0] : -1, (own_q.size() > 1) ? own_q[1] : -1);
      end
      req = 4'b0000;
   endtask

   task automatic test_dwell();
      logic [31:0] held;
      logic        idle_seen;
      reset = 1'b1; tick(); reset = 1'b0;
      data[0] = $urandom; held = data[0];
      req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();
      for (int i = 0; i < 4; i++) data[i] = $urandom;
      req = 4'b0010;
      idle_seen = 1'b0;
      for (int c = 0; c < 10 && !idle_seen; c++) begin
         tick();
         vectors++;
         if (seg_out !== held || ack !== 4'b0000) begin
            miscompares++;
            $display("FAIL dwell_freeze c%0d: got seg=%h ack=%b, want seg=%h ack=0000", c, seg_out, ack, held);
         end
         if (!busy) idle_seen = 1'b1;
      end
      vectors++;
      if (!idle_seen) begin
         miscompares++;
         $display("FAIL dwell_timeout: got busy=%b after 10 cycles, want 0", busy);
      end
      tick();
      vectors++;
      if ({ack, seg_out, owner} !== {4'b0010, data[1], 2'd1}) begin
         miscompares++;
         $display("FAIL dwell_grant: got ack=%b seg=%h own=%0d, want 0010 %h 1", ack, seg_out, owner, data[1]);
      end
      req = 4'b0000;
   endtask

   task automatic test_reset_mid_hold();
      reset = 1'b1; tick(); reset = 1'b0;
      data[2] = $urandom; req = 4'b0100;
      tick();
      req = 4'b0000;
      tick();
      reset = 1'b1; req = 4'b1010;
      tick();
      vectors++;
      if ({ack, seg_out, owner, busy} !== {4'b0000, INIT, 2'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL midreset: got ack=%b seg=%h own=%0d busy=%b, want 0000 %h 0 0",
                  ack, seg_out, owner, busy, INIT);
      end
      reset = 1'b0;
      tick();
      vectors++;
      if ({ack, seg_out, owner, busy} !== {4'b0010, data[1], 2'd1, 1'b1}) begin
         miscompares++;
         $display("FAIL midreset_grant: got ack=%b seg=%h own=%0d busy=%b, want 0010 %h 1 1",
                  ack, seg_out, owner, busy, data[1]);
      end
      req = 4'b0000;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 49) == 0);
         tick();
         vectors++;
         if ({ack, seg_out, owner, busy} !== {m_ack, m_seg, m_owner, m_busy}) begin
            miscompares++;
            $display("FAIL random c%0d: got ack=%b seg=%h own=%0d busy=%b, want ack=%b seg=%h own=%0d busy=%b",
                     c, ack, seg_out, owner, busy, m_ack, m_seg, m_owner, m_busy);
         end
         for (int i = 0; i < 4; i++) begin
            if (ack[i]) req[i] = 1'b0;
            else if (!req[i]) begin
               data[i] = $urandom;
               req[i]  = ($urandom_range(0, 3) == 0);
            end
            else if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0; req = 4'b0000;
      for (int i = 0; i < 4; i++) data[i] = 32'h0000_0000;
      m_seg = INIT; m_ack = 4'b0000; m_owner = 2'd0; m_busy = 1'b0; m_left = 0; m_last = 3;
      @(negedge clk);
      test_reset();
      test_single();
      test_full_load();
      test_priority();
      test_dwell();
      test_reset_mid_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Round-robin arbiter that shares the single 32-bit, 8-digit seven-segment display word between four requesters.
- Each requester offers a 32-bit hex word with a req/ack handshake.
- The winner's word is registered onto seg_out, which feeds the display controller's seg input, and is held for a guaranteed minimum dwell before the next requester can take the display.
- Sits between the application sources and the display controller.

Parameters:
- HOLD_CYCLES, 100_000_000: minimum clk cycles a granted word is held before re-arbitration (1 s at 100 MHz). Legal range 1 to 2^CNT_W-1.
- CNT_W, 27: dwell counter width.
- INIT_SEG, 32'h0000_0000: value of seg_out after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  req[i]: requester i has a word pending. Held high until ack[i] is seen.
- data0  input  32  requester 0 word, 8 hex nibbles, [31:28] = leftmost digit.
- data1  input  32  requester 1 word.
- data2  input  32  requester 2 word.
- data3  input  32  requester 3 word.
- ack  output  4  one-cycle pulse on ack[i] when requester i's word is captured.
- seg_out  output  32  registered display word, to the display controller's seg input.
- owner  output  2  index of the requester whose word is currently shown.
- busy  output  1  high while in the HOLD state (dwell running).

Behaviour:
- One clock; reset is synchronous and active-high. Every register is updated only on a rising clk edge.
- Reset values, also applied mid-operation on the next edge with reset=1, overriding all other activity:
  - state = IDLE
  - seg_out = INIT_SEG
  - ack = 0, owner = 0, busy = 0
  - dwell counter = 0
  - round-robin pointer last = 3, so requester 0 has top priority on the first grant.
  - A grant in flight during reset is discarded; no ack is issued for it.
- States: IDLE, HOLD.
- IDLE with req == 0: stay in IDLE, seg_out unchanged, ack = 0.
- IDLE with req != 0: the winner is the first set bit scanning last+1, last+2, last+3, last (mod 4). On that edge:
  - seg_out <= data[winner]
  - ack[winner] <= 1
  - owner <= winner, last <= winner
  - cnt <= HOLD_CYCLES-1, busy <= 1
  - state <= HOLD
- HOLD:
  - ack <= 0, so the ack pulse lasts exactly one cycle.
  - If cnt != 0: cnt <= cnt-1, stay in HOLD.
  - If cnt == 0: state <= IDLE, busy <= 0.
  - req and data are ignored throughout HOLD; seg_out is frozen.
- Latency:
  - Grant occurs at the first IDLE edge with a request.
  - ack and the new seg_out become visible in the same cycle, one cycle after that edge.
  - Minimum spacing between successive grants = HOLD_CYCLES+1 cycles. busy stays high for exactly HOLD_CYCLES cycles.
- Handshake:
  - A requester samples ack[i] and drops req[i] by the following edge.
  - A req[i] still high when the FSM returns to IDLE is treated as a new request.
  - A requester may change data only while req[i] is low, or after its ack.
- Fairness: a requester that has just been granted has the lowest priority at the next arbitration. With all four requesting continuously, grants cycle 0,1,2,3,0,...
- Idle display: the last granted word stays on seg_out indefinitely. There is no blanking.
- Boundaries:
  - HOLD_CYCLES = 1: exactly one HOLD cycle, grants every 2 cycles under full load.
  - A req that drops before ack while still in IDLE is never granted.
  - Simultaneous requests are resolved only by the pointer rule above.
- Purely synchronous. No combinational path from req/data to any output.

Test Plan (HOLD_CYCLES=4, INIT_SEG=32'hDEAD_BEEF):
1. Reset -> seg_out=DEADBEEF, ack=0, busy=0, owner=0. Reset is asserted 2 cycles with req=4'b1111; no ack appears.
2. Single request: req=4'b0100, data2=32'h1234_5678 -> one cycle later ack=4'b0100 for exactly 1 cycle, seg_out=12345678, owner=2, busy high 4 cycles, then IDLE.
3. Full load, all req held high and re-raised after each ack -> grant order 0,1,2,3,0; consecutive acks are exactly 5 cycles apart.
4. Priority after grant: grant 3, then req=4'b1001 at return to IDLE -> requester 0 wins; on the next arbitration with req=4'b1001, requester 3 wins.
5. Dwell protection: during HOLD, change data and raise req=4'b0010 -> seg_out unchanged until IDLE. Requester 1 is then granted on the first IDLE edge.
6. Reset mid-HOLD at cnt=2 -> next cycle seg_out=DEADBEEF, busy=0, last=3. With req=4'b1010 after reset, requester 1 wins.
